// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: bubble/flush generation for the five-stage RV32I pipeline.
// Optional performance counters are enabled with `define HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
    parameter int unsigned MD_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1D,
    input  logic [4:0]  rs2D,
    input  logic        rs1_usedD,
    input  logic        rs2_usedD,
    input  logic [4:0]  rdE,
    input  logic        mem_readE,
    input  logic        md_startE,
    input  logic        br_mispredictE,
    input  logic        dcache_miss,
    output logic        bubbleF,
    output logic        bubbleD,
    output logic        bubbleE,
    output logic        bubbleM,
    output logic        bubbleW,
    output logic        flushD,
    output logic        flushE,
    output logic        flushM,
    output logic        flushW,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events
);

    // state   | meaning
    // RUN     | no M-extension op in flight (or single-cycle op releasing)
    // MD_WAIT | multi-cycle op in EX, cnt counts remaining stall cycles
    typedef enum logic {RUN = 1'b0, MD_WAIT = 1'b1} state_t;

    localparam logic [3:0] MD_LOAD  = 4'(MD_LATENCY - 1);
    localparam bit         MD_MULTI = (MD_LATENCY > 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    // Marks the release cycle of a single-cycle op, which never visits MD_WAIT.
    logic       rel_q, rel_d;

    logic freeze, md_stall, load_use, mispredict_act;

    assign freeze   = dcache_miss;
    assign md_stall = ((state_q == RUN) && md_startE && !rel_q) ||
                      ((state_q == MD_WAIT) && (cnt_q != 4'd0));
    assign load_use = mem_readE && (rdE != 5'd0) &&
                      ((rs1_usedD && (rs1D == rdE)) || (rs2_usedD && (rs2D == rdE)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= 4'd0;
            rel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rel_q   <= rel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rel_d   = rel_q;
        case (state_q)
            RUN: begin
                if (rel_q) begin
                    if (!freeze) rel_d = 1'b0;
                end else if (md_startE && !freeze) begin
                    cnt_d = MD_LOAD;
                    if (MD_MULTI) state_d = MD_WAIT;
                    else          rel_d   = 1'b1;
                end
            end
            MD_WAIT: begin
                // The divider keeps running through a freeze, so cnt never pauses.
                if (cnt_q != 4'd0)  cnt_d   = cnt_q - 4'd1;
                else if (!freeze)   state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        bubbleF        = 1'b0;
        bubbleD        = 1'b0;
        bubbleE        = 1'b0;
        bubbleM        = 1'b0;
        bubbleW        = 1'b0;
        flushD         = 1'b0;
        flushE         = 1'b0;
        flushM         = 1'b0;
        flushW         = 1'b0;
        mispredict_act = 1'b0;
        if (rst) begin
            flushD = 1'b1;
            flushE = 1'b1;
            flushM = 1'b1;
            flushW = 1'b1;
        end else if (freeze) begin
            bubbleF = 1'b1;
            bubbleD = 1'b1;
            bubbleE = 1'b1;
            bubbleM = 1'b1;
            flushW  = 1'b1;
        end else if (md_stall) begin
            bubbleF = 1'b1;
            bubbleD = 1'b1;
            bubbleE = 1'b1;
            flushM  = 1'b1;
        end else if (br_mispredictE) begin
            flushD         = 1'b1;
            flushE         = 1'b1;
            mispredict_act = 1'b1;
        end else if (load_use) begin
            bubbleF = 1'b1;
            bubbleD = 1'b1;
            flushE  = 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_events_q, flush_events_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q + 32'(bubbleF);
        flush_events_d = flush_events_q + 32'(mispredict_act);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_q <= 32'd0;
            flush_events_q <= 32'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;
`else
    assign stall_cycles = 32'd0;
    assign flush_events = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (MD_LATENCY 4 and 1) checked every cycle
// against a cycle-numbered reference model, plus directed scenarios.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1D, rs2D, rdE;
    logic       rs1_usedD, rs2_usedD, mem_readE, md_startE, br_mispredictE, dcache_miss;

    logic        bF[2], bD[2], bE[2], bM[2], bW[2], fD[2], fE[2], fM[2], fW[2];
    logic [31:0] sc[2], fe[2];
    logic [8:0]  obs[2];

    always #5 clk = ~clk;

    hazard_ctrl #(.MD_LATENCY(4)) dut (
        .clk(clk), .rst(rst), .rs1D(rs1D), .rs2D(rs2D), .rs1_usedD(rs1_usedD),
        .rs2_usedD(rs2_usedD), .rdE(rdE), .mem_readE(mem_readE), .md_startE(md_startE),
        .br_mispredictE(br_mispredictE), .dcache_miss(dcache_miss),
        .bubbleF(bF[0]), .bubbleD(bD[0]), .bubbleE(bE[0]), .bubbleM(bM[0]), .bubbleW(bW[0]),
        .flushD(fD[0]), .flushE(fE[0]), .flushM(fM[0]), .flushW(fW[0]),
        .stall_cycles(sc[0]), .flush_events(fe[0]));

    hazard_ctrl #(.MD_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .rs1D(rs1D), .rs2D(rs2D), .rs1_usedD(rs1_usedD),
        .rs2_usedD(rs2_usedD), .rdE(rdE), .mem_readE(mem_readE), .md_startE(md_startE),
        .br_mispredictE(br_mispredictE), .dcache_miss(dcache_miss),
        .bubbleF(bF[1]), .bubbleD(bD[1]), .bubbleE(bE[1]), .bubbleM(bM[1]), .bubbleW(bW[1]),
        .flushD(fD[1]), .flushE(fE[1]), .flushM(fM[1]), .flushW(fW[1]),
        .stall_cycles(sc[1]), .flush_events(fe[1]));

    assign obs[0] = {bF[0], bD[0], bE[0], bM[0], bW[0], fD[0], fE[0], fM[0], fW[0]};
    assign obs[1] = {bF[1], bD[1], bE[1], bM[1], bW[1], fD[1], fE[1], fM[1], fW[1]};

    // Reference model: an M op accepted at cycle s stalls cycles s..s+lat-1 and
    // completes at the first cycle >= s+lat without a freeze.
    int unsigned lat[2] = '{4, 1};
    bit          busy[2];
    longint      start[2];
    longint      cyc = 0;
    int unsigned m_st[2], m_fl[2];

    logic [8:0]  last_obs[2];
    logic [31:0] last_sc[2], last_fe[2];

    int passed = 0, total = 0, fails = 0;

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, o, e, cyc);
        end
    endtask

    task automatic tick();
        bit          nbusy[2];
        longint      nstart[2];
        int unsigned nst[2], nfl[2];
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            bit frz, mds, rel, lu, fl_act;
            logic [8:0] e;
            frz = dcache_miss;
            mds = (!busy[i] && md_startE) || (busy[i] && (cyc < start[i] + longint'(lat[i])));
            rel = busy[i] && (cyc >= start[i] + longint'(lat[i]));
            lu  = mem_readE && (rdE != 0) &&
                  ((rs1_usedD && rs1D == rdE) || (rs2_usedD && rs2D == rdE));
            fl_act = 1'b0;
            if (rst)                 e = 9'b000001111;
            else if (frz)            e = 9'b111100001;
            else if (mds)            e = 9'b111000010;
            else if (br_mispredictE) begin e = 9'b000001100; fl_act = 1'b1; end
            else if (lu)             e = 9'b110000100;
            else                     e = 9'b000000000;
            last_obs[i] = obs[i];
            last_sc[i]  = sc[i];
            last_fe[i]  = fe[i];
            check(i == 0 ? "outs_lat4" : "outs_lat1", 32'(obs[i]), 32'(e));
`ifdef HAZARD_PERF_CNT_EN
            check("stall_cycles", sc[i], rst ? 32'd0 : m_st[i]);
            check("flush_events", fe[i], rst ? 32'd0 : m_fl[i]);
`else
            check("perf_tied0", sc[i] | fe[i], 32'd0);
`endif
            nbusy[i]  = busy[i];
            nstart[i] = start[i];
            if (rst) nbusy[i] = 1'b0;
            else if (!busy[i] && md_startE && !frz) begin nbusy[i] = 1'b1; nstart[i] = cyc; end
            else if (rel && !frz) nbusy[i] = 1'b0;
            nst[i] = rst ? 0 : m_st[i] + (e[8] ? 1 : 0);
            nfl[i] = rst ? 0 : m_fl[i] + (fl_act ? 1 : 0);
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            busy[i]  = nbusy[i];
            start[i] = nstart[i];
            m_st[i]  = nst[i];
            m_fl[i]  = nfl[i];
        end
        cyc++;
        #1;
    endtask

    task automatic clr_in();
        rst = 0; rs1D = 0; rs2D = 0; rdE = 0; rs1_usedD = 0; rs2_usedD = 0;
        mem_readE = 0; md_startE = 0; br_mispredictE = 0; dcache_miss = 0;
    endtask

    initial begin
        int cntE, cntE1, cntM;
        logic [31:0] f0;
        clr_in();
        rst = 1; md_startE = 1;
        tick();
        check("reset_lat4", 32'(last_obs[0]), 32'h00F);
        check("reset_lat1", 32'(last_obs[1]), 32'h00F);
        tick();
        rst = 0; md_startE = 0;
        tick();
        check("idle_after_reset", 32'(last_obs[0]), 32'h000);

        // Load-use through rs2, then the same with x0 as destination.
        mem_readE = 1; rdE = 5; rs2D = 5; rs2_usedD = 1;
        tick();
        check("load_use", 32'(last_obs[0]), 32'h184);
        clr_in();
        tick();
        check("load_use_one_cycle", 32'(last_obs[0]), 32'h000);
        mem_readE = 1; rdE = 0; rs2D = 0; rs2_usedD = 1;
        tick();
        check("load_use_x0", 32'(last_obs[0]), 32'h000);
        clr_in();

        // Single MUL: held for stall cycles plus the release cycle.
        cntE = 0;
        md_startE = 1;
        repeat (5) begin
            tick();
            if (last_obs[0][6] && last_obs[0][1]) cntE++;
        end
        check("mul_stall_cycles", 32'(cntE), 32'd4);
        check("mul_release", 32'(last_obs[0]), 32'h000);
        // Back-to-back MULs.
        cntE = 0;
        repeat (10) begin
            tick();
            if (last_obs[0][6]) cntE++;
        end
        check("mul_b2b_stalls", 32'(cntE), 32'd8);
        md_startE = 0;
        repeat (6) tick();

        // Latency-1 instance: one stall then release.
        cntE1 = 0;
        md_startE = 1;
        repeat (2) begin
            tick();
            if (last_obs[1][6]) cntE1++;
        end
        check("mul_lat1_stalls", 32'(cntE1), 32'd1);
        check("mul_lat1_release", 32'(last_obs[1]), 32'h000);
        md_startE = 0;
        repeat (6) tick();

        // Freeze starting one cycle into the MD wait.
        md_startE = 1;
        tick();
        cntM = 0;
        dcache_miss = 1;
        repeat (6) begin
            tick();
            if (last_obs[0][5]) cntM++;
        end
        check("freeze_bubbleM", 32'(cntM), 32'd6);
        dcache_miss = 0;
        tick();
        check("freeze_release", 32'(last_obs[0]), 32'h000);
        md_startE = 0;
        repeat (6) tick();

        // Mispredict and load-use together.
        br_mispredictE = 1; mem_readE = 1; rdE = 5; rs2D = 5; rs2_usedD = 1;
        tick();
        check("mispredict_over_lu", 32'(last_obs[0]), 32'h00C);
        f0 = last_fe[0];
        clr_in();
        tick();
`ifdef HAZARD_PERF_CNT_EN
        check("flush_events_inc", last_fe[0] - f0, 32'd1);
        // Stall counter wraps.
        force dut.stall_cycles_q = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cycles_q;
        m_st[0] = 32'hFFFF_FFFF;
        dcache_miss = 1;
        tick();
        dcache_miss = 0;
        tick();
        check("stall_wrap", last_sc[0], 32'd0);
`else
        check("flush_events_tied", last_fe[0] | f0, 32'd0);
`endif

        // Randomized traffic.
        repeat (800) begin
            rst            = ($urandom_range(0, 99) == 0);
            dcache_miss    = ($urandom_range(0, 5) == 0);
            md_startE      = ($urandom_range(0, 3) == 0);
            br_mispredictE = ($urandom_range(0, 5) == 0);
            mem_readE      = ($urandom_range(0, 2) == 0);
            rs1_usedD      = 1'($urandom_range(0, 1));
            rs2_usedD      = 1'($urandom_range(0, 1));
            rdE            = 5'($urandom_range(0, 3));
            rs1D           = 5'($urandom_range(0, 3));
            rs2D           = 5'($urandom_range(0, 3));
            tick();
        end
        clr_in();
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage RV32I core: generates every `bubble*` (hold) and `flush*` (clear to zero/NOP) signal consumed by the IF/ID, ID/EX, EX/MEM and MEM/WB segment registers. Detects load-use hazards, branch mispredicts, multi-cycle multiply/divide occupancy, and data-cache miss freezes. Holds a small FSM and down-counter for the M-extension wait. Optional performance counters.

## Interface
- `MD_LATENCY`, 4: total stall cycles for an M-extension op in EX; legal range 1..15.
- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-high reset
- `rs1D`, `rs2D`  in  5 each  source registers of the instruction in ID
- `rs1_usedD`, `rs2_usedD`  in  1 each  source actually read by the ID instruction
- `rdE`  in  5  destination of the EX instruction
- `mem_readE`  in  1  EX instruction is a load
- `md_startE`  in  1  EX holds a MUL/DIV instruction
- `br_mispredictE`  in  1  EX resolved branch/jump disagrees with `predict_taken_E`
- `dcache_miss`  in  1  level; MEM access outstanding, high until data ready
- `bubbleF`, `bubbleD`, `bubbleE`, `bubbleM`, `bubbleW`  out  1 each  hold stage register
- `flushD`, `flushE`, `flushM`, `flushW`  out  1 each  clear stage register (ignored by a register whose bubble is high)
- `stall_cycles`  out  32  perf counter (only with macro)
- `flush_events`  out  32  perf counter (only with macro)

## Operation
- State: `RUN`, `MD_WAIT`; 4-bit counter `cnt`.
- Conditions:
  - `freeze` = `dcache_miss`.
  - `md_stall` = (`RUN` & `md_startE`) | (`MD_WAIT` & `cnt`≠0).
  - `load_use` = `mem_readE` & `rdE`≠0 & ((`rs1_usedD` & `rs1D`==`rdE`) | (`rs2_usedD` & `rs2D`==`rdE`)).
- Outputs (combinational from state/inputs), strict priority, first match wins:
  1. `rst`: all bubbles 0; `flushD/E/M/W`=1.
  2. `freeze`: `bubbleF/D/E/M`=1, `flushW`=1; all else 0.
  3. `md_stall`: `bubbleF/D/E`=1, `flushM`=1.
  4. `br_mispredictE`: `flushD`=1, `flushE`=1.
  5. `load_use`: `bubbleF`=1, `bubbleD`=1, `flushE`=1.
  6. Otherwise all 0.
- FSM:
  - `RUN` & `md_startE` & !`freeze`: `cnt`←`MD_LATENCY`-1; go to `MD_WAIT` if `MD_LATENCY`>1, else stay in `RUN`.
  - `MD_WAIT`: `cnt` decrements every cycle, saturates at 0, and keeps counting during `freeze` (the divider runs independently).
  - `MD_WAIT` & `cnt`==0 & !`freeze` → `RUN`. The cycle with `cnt`==0 is a release cycle; `md_startE` is ignored in it.
- `md_startE` and `br_mispredictE` both high: md stall wins; the mispredict is acted on in the release cycle, because EX is held.
- Mispredict or load-use during `freeze` is not lost: EX/ID are held, so the condition re-presents once `freeze` drops.

## Timing
- Reset: state `RUN`, `cnt`=0, perf counters 0; output values as in priority 1 while `rst`=1.
- MUL/DIV in EX at cycle T (`RUN`) with no freeze: stalled cycles T..T+`MD_LATENCY`-1; the instruction leaves EX at the edge ending cycle T+`MD_LATENCY`.
- Load-use: exactly one bubble cycle.
- Mispredict: zero stall; two wrong-path slots are cleared at the next edge.
- Freeze: zero added latency; the pipeline resumes in the cycle `dcache_miss` falls.
- `rst` mid-`MD_WAIT`: immediate return to `RUN`, `cnt`=0.

## Configuration
- `HAZARD_PERF_CNT_EN` defined:
  - `stall_cycles` increments on every non-reset cycle with `bubbleF`=1.
  - `flush_events` increments on every cycle where priority 4 is the active case.
  - Both counters wrap modulo 2^32.
- Not defined: no counter flops; both outputs tied to 0.

## Test plan
- Reset: `rst`=1 with `md_startE`=1 → `flushD/E/M/W`=1, all bubbles 0; after release, `RUN`, no stall.
- Load-use: `mem_readE`=1, `rdE`=5, `rs2D`=5, `rs2_usedD`=1 → one cycle of `bubbleF`=`bubbleD`=`flushE`=1. Same with `rdE`=0 → no stall.
- MUL with `MD_LATENCY`=4: `md_startE` held until EX advances → exactly 4 cycles of `bubbleE`=`flushM`=1, then the release cycle; back-to-back MULs give 4+4 stalls. Repeat with `MD_LATENCY`=1: one stall cycle, no entry to `MD_WAIT`.
- Freeze inside MD wait: `dcache_miss` high for 6 cycles starting 1 cycle after `md_startE` (`MD_LATENCY`=4) → `bubbleM` high for 6 cycles; release on the first cycle `dcache_miss`=0, since `cnt` is already 0.
- Mispredict with load-use in the same cycle → only `flushD`=`flushE`=1, `bubbleF`=0; with macro, `flush_events` increments by 1.
- Perf wrap: preload `stall_cycles`=0xFFFFFFFF via force, one stall cycle → reads 0.
